zc_period_avg: RTL

Downstream averaging stage for `zero_crossing_detect`. Consumes the stream of signed half-period counts the detector emits, one word per zero crossing, and accumulates blocks of 2^N words. It emits one signed block average per block, with a mixed-sign flag and a no-signal timeout flag, for the Doppler tracker's frequency estimator.

---
 rtl/zc_period_avg_pkg.sv | 25 ++
 rtl/zc_avg_out_reg.sv | 41 ++++
 rtl/zc_period_avg.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/zc_period_avg_pkg.sv
// Shared Doppler-tracker definitions: FSM encoding, accumulator sizing, length clamp.
package zc_period_avg_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StAccum = 1'b1
    } state_e;

    localparam int unsigned LogLenW = 4;

    // Accumulator must hold 2^max_log_avg words of counter_size bits without overflow.
    function automatic int unsigned acc_width(input int unsigned counter_size,
                                              input int unsigned max_log_avg);
        return counter_size + max_log_avg;
    endfunction

    function automatic logic [LogLenW-1:0] clamp_log_len(input logic [LogLenW-1:0] len,
                                                         input int unsigned max_len);
        if (32'(len) > max_len) begin
            return LogLenW'(max_len);
        end
        return len;
    endfunction

endpackage

// File: rtl/zc_avg_out_reg.sv
// One-entry output holding register with overwrite detection and saturating overrun count.
module zc_avg_out_reg #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              emit,
    input  logic [DATA_W-1:0] emit_data,
    input  logic              emit_mixed,
    input  logic              emit_timeout,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              mixed,
    output logic              timeout_flag,
    output logic [15:0]       overrun_count
);

    // Load on emit, drop on consumption, count words overwritten before being taken.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            valid         <= 1'b0;
            data          <= '0;
            mixed         <= 1'b0;
            timeout_flag  <= 1'b0;
            overrun_count <= '0;
        end else if (emit) begin
            valid        <= 1'b1;
            data         <= emit_data;
            mixed        <= emit_mixed;
            timeout_flag <= emit_timeout;
            if (valid && !ready && overrun_count != 16'hFFFF) begin
                overrun_count <= overrun_count + 16'd1;
            end
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/zc_period_avg.sv
// Block averager for zero-crossing half-period counts: 2^N words in, one average out.
module zc_period_avg
    import zc_period_avg_pkg::*;
#(
    parameter int unsigned COUNTER_SIZE = 32,
    parameter int unsigned MAX_LOG_AVG  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [3:0]              log_avg_len,
    input  logic [31:0]             timeout,
    input  logic [COUNTER_SIZE-1:0] i_tdata,
    input  logic                    i_tvalid,
    input  logic                    i_tlast,
    output logic                    i_tready,
    output logic [COUNTER_SIZE-1:0] o_tdata,
    output logic                    o_tvalid,
    output logic                    o_tlast,
    input  logic                    o_tready,
    output logic                    o_mixed,
    output logic                    o_timeout,
    output logic [15:0]             overrun_count
);

    localparam int unsigned AccW = acc_width(COUNTER_SIZE, MAX_LOG_AVG);
    localparam int unsigned CntW = MAX_LOG_AVG + 1;

    state_e                   state_q, state_d;
    logic [3:0]               len_q, len_d, len_clamped;
    logic signed [AccW-1:0]   acc_q, acc_d, sample_ext, sum, avg;
    logic [CntW-1:0]          cnt_q, cnt_d, cnt_inc, cnt_target;
    logic                     first_sign_q, first_sign_d;
    logic                     mixed_q, mixed_d;
    logic [31:0]              tmr_q, tmr_d;
    logic                     timeout_hit, sample_mixed, block_done;
    logic                     emit, emit_mixed, emit_timeout;
    logic [COUNTER_SIZE-1:0]  emit_data;
    logic                     unused_bits;

    assign i_tready     = 1'b1;
    assign o_tlast      = 1'b0;
    assign len_clamped  = clamp_log_len(log_avg_len, MAX_LOG_AVG);
    assign sample_ext   = {{MAX_LOG_AVG{i_tdata[COUNTER_SIZE-1]}}, i_tdata};
    assign sum          = acc_q + sample_ext;
    assign avg          = sum >>> len_q;
    assign cnt_inc      = cnt_q + CntW'(1);
    assign cnt_target   = CntW'(1) << len_q;
    assign block_done   = (cnt_inc == cnt_target);
    assign sample_mixed = (i_tdata[COUNTER_SIZE-1] != first_sign_q);
    // Timer counts idle cycles already elapsed, so hitting timeout-1 means this is the Nth.
    assign timeout_hit  = (timeout != 32'd0) && (tmr_q == timeout - 32'd1);
    assign unused_bits  = ^{i_tlast, avg[AccW-1:COUNTER_SIZE]};

    // State register.
    always_ff @(posedge clk) begin
        if (!reset || clear) state_q <= StIdle;
        else                 state_q <= state_d;
    end

    // Next-state logic: zero-length blocks never leave IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (i_tvalid && len_clamped != 4'd0) state_d = StAccum;
            StAccum: begin
                if (i_tvalid) begin
                    if (block_done) state_d = StIdle;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode: block completion or timeout marker.
    always_comb begin
        emit         = 1'b0;
        emit_data    = '0;
        emit_mixed   = 1'b0;
        emit_timeout = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_tvalid && len_clamped == 4'd0) begin
                    emit      = 1'b1;
                    emit_data = i_tdata;
                end
            end
            StAccum: begin
                if (i_tvalid) begin
                    if (block_done) begin
                        emit       = 1'b1;
                        emit_data  = avg[COUNTER_SIZE-1:0];
                        emit_mixed = mixed_q | sample_mixed;
                    end
                end else if (timeout_hit) begin
                    emit         = 1'b1;
                    emit_timeout = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath next-state: block start in IDLE, accumulate or age the timer in ACCUM.
    always_comb begin
        len_d        = len_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        first_sign_d = first_sign_q;
        mixed_d      = mixed_q;
        tmr_d        = tmr_q;
        if (state_q == StIdle) begin
            if (i_tvalid) begin
                len_d        = len_clamped;
                acc_d        = sample_ext;
                cnt_d        = CntW'(1);
                first_sign_d = i_tdata[COUNTER_SIZE-1];
                mixed_d      = 1'b0;
                tmr_d        = '0;
            end
        end else if (i_tvalid) begin
            acc_d   = sum;
            cnt_d   = cnt_inc;
            mixed_d = mixed_q | sample_mixed;
            tmr_d   = '0;
        end else begin
            tmr_d = tmr_q + 32'd1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            len_q        <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            first_sign_q <= 1'b0;
            mixed_q      <= 1'b0;
            tmr_q        <= '0;
        end else begin
            len_q        <= len_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            first_sign_q <= first_sign_d;
            mixed_q      <= mixed_d;
            tmr_q        <= tmr_d;
        end
    end

    zc_avg_out_reg #(
        .DATA_W (COUNTER_SIZE)
    ) u_out_reg (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .emit          (emit),
        .emit_data     (emit_data),
        .emit_mixed    (emit_mixed),
        .emit_timeout  (emit_timeout),
        .ready         (o_tready),
        .valid         (o_tvalid),
        .data          (o_tdata),
        .mixed         (o_mixed),
        .timeout_flag  (o_timeout),
        .overrun_count (overrun_count)
    );

endmodule
